// File: rtl/seq_comparator_if.sv
// Start/result bundle for the sliced magnitude comparator.
// Master issues operands, slave returns busy/done and flags.
interface seq_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, signed_mode, X, Y,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, signed_mode, X, Y,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator, one SLICE per clock,
// MS slice first, early exit on first differing slice.
module seq_comparator #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic           clk,
  input logic           rst_n,
  seq_comparator_if.slave bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sgn_q, sgn_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic [SLICE-1:0] xs;
  logic [SLICE-1:0] ys;
  logic             top;
  logic             last;
  logic             split;

  always_comb begin
    xs = '0;
    ys = '0;
    for (int i = 0; i < NSL; i++) begin
      if (cnt_q == CW'(i)) begin
        xs = x_q[i*SLICE +: SLICE];
        ys = y_q[i*SLICE +: SLICE];
      end
    end
  end

  assign top  = (cnt_q == CW'(NSL-1));
  assign last = (cnt_q == '0);
  // Sign mismatch decides a signed compare outright.
  assign split = top && sgn_q &&
                 (x_q[WIDTH-1] != y_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    sgn_d   = sgn_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.X;
          y_d     = bus.Y;
          sgn_d   = bus.signed_mode;
          cnt_d   = CW'(NSL-1);
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (split) begin
          lt_d    = x_q[WIDTH-1];
          gt_d    = ~x_q[WIDTH-1];
          state_d = DONE;
        end else if (xs > ys) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (xs < ys) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (last) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sgn_q   <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sgn_q   <= sgn_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Self-checking bench for seq_comparator: directed plan
// cases plus randomized operands against a reference model.
module tb_seq_comparator;

  localparam int W   = 32;
  localparam int S   = 8;
  localparam int NSL = W / S;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  seq_comparator_if #(.WIDTH(W)) bus ();

  seq_comparator #(
    .WIDTH(W),
    .SLICE(S)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Expected {lt,eq,gt} straight from arithmetic.
  function automatic logic [2:0] ref_flags(
    logic [31:0] x, logic [31:0] y, bit s);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (s) begin
      if (sx < sy) return 3'b100;
      if (sx > sy) return 3'b001;
      return 3'b010;
    end
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return 3'b010;
  endfunction

  // Scan cycles: NSL minus index of top differing slice.
  function automatic int ref_k(logic [31:0] x,
                               logic [31:0] y);
    logic [31:0] d;
    d = x ^ y;
    for (int s = NSL-1; s >= 0; s--)
      if (((d >> (s*S)) & 32'hFF) != 0) return NSL - s;
    return NSL;
  endfunction

  function automatic logic [2:0] flags();
    return {bus.lt, bus.eq, bus.gt};
  endfunction

  task automatic run_cmp(input logic [31:0] x,
                         input logic [31:0] y,
                         input bit s, input bit scr,
                         input string tag);
    int k;
    logic [2:0] ef;
    k  = ref_k(x, y);
    ef = ref_flags(x, y, s);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.X           = x;
    bus.Y           = y;
    bus.signed_mode = s;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c <= k + 2; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (scr) begin
        bus.X = $urandom;
        bus.Y = $urandom;
        bus.signed_mode = ~s;
      end
      if (c <= k) begin
        chk({tag, "_scan_busy"}, 32'(bus.busy), 1);
        chk({tag, "_scan_done"}, 32'(bus.done), 0);
        chk({tag, "_scan_flags"}, 32'(flags()), 0);
      end else if (c == k + 1) begin
        chk({tag, "_done"}, 32'(bus.done), 1);
        chk({tag, "_done_busy"}, 32'(bus.busy), 1);
        chk({tag, "_flags"}, 32'(flags()), 32'(ef));
      end else begin
        chk({tag, "_idle_busy"}, 32'(bus.busy), 0);
        chk({tag, "_idle_done"}, 32'(bus.done), 0);
        chk({tag, "_hold_flags"}, 32'(flags()), 32'(ef));
      end
    end
  endtask

  initial begin
    logic [31:0] x, y, m, t;
    int          sel;
    int          acc;
    bit          exp_done [0:20];
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.signed_mode = 1'b0;
    bus.X           = '0;
    bus.Y           = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_flags", 32'(flags()), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_cmp(32'd9, 32'd7, 1'b0, 1'b0, "u_late");
    run_cmp(32'h12345678, 32'h12345678, 1'b0, 1'b0, "eq_big");
    run_cmp(32'd4, 32'd4, 1'b0, 1'b0, "eq_small");
    run_cmp(32'h01000000, 32'h00FFFFFF, 1'b0, 1'b0, "early");
    run_cmp(32'd1, 32'd5, 1'b0, 1'b0, "lt_late");
    run_cmp(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, "s_neg");
    run_cmp(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, "u_big");
    run_cmp(32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, "s_both");
    run_cmp(32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, "s_ext");
    run_cmp(32'd30, 32'd21, 1'b0, 1'b1, "scramble");

    // Start held high: one accept per IDLE visit.
    for (int i = 0; i <= 20; i++) exp_done[i] = 1'b0;
    acc = 0;
    while (acc < 10) begin
      if (acc + ref_k(30, 21) + 1 <= 20)
        exp_done[acc + ref_k(30, 21) + 1] = 1'b1;
      acc = acc + ref_k(30, 21) + 2;
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 32'd30;
    bus.Y     = 32'd21;
    bus.signed_mode = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 10) bus.start = 1'b0;
      chk("hs_done", 32'(bus.done), 32'(exp_done[c]));
      if (exp_done[c])
        chk("hs_flags", 32'(flags()), 32'(3'b001));
    end

    // Reset in cycle 2 aborts the compare.
    @(negedge clk);
    bus.start = 1'b1;
    bus.X     = 32'd56;
    bus.Y     = 32'd18;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("ra_busy", 32'(bus.busy), 0);
    chk("ra_done", 32'(bus.done), 0);
    chk("ra_flags", 32'(flags()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("ra_nodone", 32'(bus.done), 0);
    end
    run_cmp(32'd56, 32'd18, 1'b0, 1'b0, "ra_fresh");

    for (int n = 0; n < 60; n++) begin
      x   = $urandom;
      sel = $urandom_range(0, 4);
      if (sel == 4) begin
        y = x;
      end else begin
        m = (32'h1 << (8 * sel)) - 32'h1;
        t = 32'($urandom_range(1, 255)) << (8 * sel);
        y = (x ^ t) ^ ($urandom & m);
      end
      if ($urandom_range(0, 1) == 1) begin
        t = x;
        x = y;
        y = t;
      end
      run_cmp(x, y, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_comparator.md
# seq_comparator

Parametrised, multi-cycle magnitude comparator that scans two WIDTH-bit operands one SLICE-bit slice per clock, most-significant slice first, and terminates early on the first differing slice. It is the successor to the 16-bit combinational comparator. It adds generic width, signed/unsigned mode and a start/done handshake. It serves datapath compare/branch logic where a full-width combinational compare would limit clock frequency.

## Interface
- WIDTH, 32, operand width in bits; must be a positive multiple of SLICE
- SLICE, 8, bits compared per cycle; NSL = WIDTH/SLICE slices, slice NSL-1 is most significant

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a compare; accepted only in IDLE
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- X  input  WIDTH  operand X; sampled with start
- Y  input  WIDTH  operand Y; sampled with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; result flags valid
- lt  output  1  X < Y
- eq  output  1  X == Y
- gt  output  1  X > Y

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, start=1:
  - latch X, Y and signed_mode into internal registers
  - set slice counter cnt = NSL-1
  - clear lt/eq/gt to 0
  - go to SCAN
- IDLE, start=0: hold all outputs.
- SCAN, one slice per cycle. Compare slice cnt of latched X vs Y (bits cnt*SLICE+SLICE-1 .. cnt*SLICE).
  - Top slice (cnt = NSL-1), signed_mode=1, sign bits differ: X sign=1 gives lt=1; X sign=0 gives gt=1. Go to DONE.
  - Otherwise, slices compared as unsigned. This is valid for signed operands once sign bits are equal.
  - Slice X > slice Y: register gt=1, go to DONE.
  - Slice X < slice Y: register lt=1, go to DONE.
  - Slices equal, cnt==0: register eq=1, go to DONE.
  - Slices equal, cnt>0: decrement cnt, stay in SCAN.
- DONE:
  - done=1 for exactly this cycle
  - go to IDLE unconditionally
- Flags:
  - exactly one of lt/eq/gt is 1 from the DONE cycle until the next accepted start
  - all three are 0 while SCAN is in progress
- start while busy is ignored, including during DONE. It is not queued.
- Input operands may change freely after the accept cycle; only latched copies are used.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, cnt=0
  - busy=0, done=0, lt=0, eq=0, gt=0
  - internal operand registers=0
- Reset mid-SCAN or in DONE aborts the compare: no done pulse, flags 0 next cycle.
- Cycle numbering: start sampled high at the end of cycle 0.
  - SCAN occupies cycles 1..k, where k = 1 + (NSL-1 - index of first differing slice), or k = NSL if the operands are equal.
  - DONE with done=1 and valid flags occurs in cycle k+1.
  - IDLE is reached in cycle k+2; the earliest next accepted start is in cycle k+2.
- Latency bounds:
  - minimum 2 cycles, start to done (top-slice difference or sign mismatch)
  - maximum NSL+1 cycles
- busy is 1 in cycles 1..k+1 and 0 in cycle k+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned, late decision: WIDTH=32, SLICE=8, signed_mode=0, X=9, Y=7, start in cycle 0 -> gt=1, lt=eq=0, done in cycle 5, busy cycles 1-5.
- Equality: X=Y=0x12345678 -> eq=1, done in cycle 5. Then X=4, Y=4 -> eq=1, next start accepted in cycle 6.
- Early exit: X=0x01000000, Y=0x00FFFFFF unsigned -> gt=1, done in cycle 2. X=1, Y=5 -> lt=1, done in cycle 5.
- Signed vs unsigned: X=0xFFFFFFFF, Y=0x00000001.
  - signed_mode=1 -> lt=1, done in cycle 2
  - signed_mode=0 -> gt=1, done in cycle 2
  - X=0xFFFFFFFE, Y=0xFFFFFFFF, signed_mode=1 -> lt=1, done in cycle 5
- Handshake: start held high for 10 cycles with X=30, Y=21 -> exactly one compare per IDLE visit, gt=1.
  - Changing X/Y during SCAN does not alter the result.
  - Flags read 0 in cycles 1..k.
- Reset mid-operation: start X=56, Y=18; rst_n=0 in cycle 2 -> cycle 3 shows busy=done=lt=eq=gt=0, no done pulse. A fresh start then completes normally with gt=1.
